// File: rtl/sequential_divider.sv
`timescale 1ns/1ps
// Iterative unsigned restoring divider: one quotient bit per clock, with
// valid/ready handshakes on both the operand and the result side.
module sequential_divider #(
    parameter int input_width  = 4,
    parameter int output_width = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [output_width-1:0] dividend,
    input  logic [input_width-1:0]  divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [output_width-1:0] quotient,
    output logic [input_width-1:0]  remainder,
    output logic                    div_by_zero
);

    // Extra MSB flags "all steps done" once the counter wraps below zero.
    localparam int count_w = $clog2(output_width) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state, state_next;
    logic [output_width-1:0] dividend_reg, quotient_reg;
    logic [input_width-1:0]  divisor_reg, partial_rem, rem_next;
    logic [count_w-1:0]      count;
    logic                    dbz_reg;
    logic [input_width:0]    trial;
    logic                    trial_ge;
    logic                    accept;
    logic                    steps_done;

    assign accept     = (state == IDLE) && in_valid;
    assign steps_done = count[count_w-1];

    // Handshake outputs decode the state register only.
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = partial_rem;
    assign div_by_zero = dbz_reg;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
            CALC: if (steps_done) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Trial is one bit wider than the divisor so the compare cannot overflow.
    always_comb begin
        trial    = {partial_rem, dividend_reg[output_width-1]};
        trial_ge = (trial >= {1'b0, divisor_reg});
        rem_next = trial_ge ? input_width'(trial - {1'b0, divisor_reg})
                            : trial[input_width-1:0];
    end

    // NOTE: every datapath register is reset so no residue of an aborted divide survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_reg <= '0;
            divisor_reg  <= '0;
            partial_rem  <= '0;
            quotient_reg <= '0;
            count        <= '0;
            dbz_reg      <= 1'b0;
        end else if (accept) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            if (divisor == '0) begin
                quotient_reg <= '1;
                partial_rem  <= dividend[input_width-1:0];
                dbz_reg      <= 1'b1;
            end else begin
                quotient_reg <= '0;
                partial_rem  <= '0;
                count        <= count_w'(output_width - 1);
                dbz_reg      <= 1'b0;
            end
        end else if (state == CALC && !steps_done) begin
            dividend_reg <= dividend_reg << 1;
            partial_rem  <= rem_next;
            quotient_reg <= {quotient_reg[output_width-2:0], trial_ge};
            count        <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
`timescale 1ns/1ps
// Self-checking bench for sequential_divider: directed vector table, multi-cycle
// corner sequences (backpressure, abort by reset) and a full operand sweep.
module tb_sequential_divider;

    localparam int IW = 4;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [OW-1:0] dividend = '0;
    logic [IW-1:0] divisor = '0;
    logic          in_ready, out_valid, div_by_zero;
    logic [OW-1:0] quotient;
    logic [IW-1:0] remainder;

    int errors = 0;
    int checks = 0;

    sequential_divider #(.input_width(IW), .output_width(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] a;
        logic [IW-1:0] b;
        logic [OW-1:0] q;
        logic [IW-1:0] r;
        logic          dbz;
        int            lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Latency = posedges after the accept edge until out_valid is seen high.
    task automatic run_div(input string tag, input logic [OW-1:0] a, input logic [IW-1:0] b,
                           input logic [OW-1:0] q, input logic [IW-1:0] r, input logic dbz,
                           input int lat, output logic [OW-1:0] q_got, output logic [IW-1:0] r_got);
        int seen;
        @(negedge clk);
        check($sformatf("%s in_ready before", tag), 32'(in_ready), 1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        check($sformatf("%s in_ready busy", tag), 32'(in_ready), 0);
        seen = 0;
        while (!out_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        q_got = quotient;
        r_got = remainder;
        check($sformatf("%s latency", tag), 32'(seen), 32'(lat));
        check($sformatf("%s out_valid", tag), 32'(out_valid), 1);
        check($sformatf("%s quotient", tag), 32'(quotient), 32'(q));
        check($sformatf("%s remainder", tag), 32'(remainder), 32'(r));
        check($sformatf("%s div_by_zero", tag), 32'(div_by_zero), 32'(dbz));
        @(negedge clk);
        check($sformatf("%s out_valid after hs", tag), 32'(out_valid), 0);
        check($sformatf("%s in_ready after hs", tag), 32'(in_ready), 1);
    endtask

    initial begin
        logic [OW-1:0] qg;
        logic [IW-1:0] rg;
        int seen;

        vecs[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9};
        vecs[1]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 9};
        vecs[2]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 9};
        vecs[3]  = '{8'd77,  4'd0,  8'd255, 4'd13, 1'b1, 0};
        vecs[4]  = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0, 9};
        vecs[5]  = '{8'd100, 4'd9,  8'd11,  4'd1,  1'b0, 9};
        vecs[6]  = '{8'd8,   4'd15, 8'd0,   4'd8,  1'b0, 9};
        vecs[7]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 9};
        vecs[8]  = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 9};
        vecs[9]  = '{8'd129, 4'd2,  8'd64,  4'd1,  1'b0, 9};
        vecs[10] = '{8'd0,   4'd0,  8'd255, 4'd0,  1'b1, 0};

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset in_ready", 32'(in_ready), 1);
        check("reset quotient", 32'(quotient), 0);
        check("reset remainder", 32'(remainder), 0);
        check("reset div_by_zero", 32'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, back-to-back with earliest possible accepts
        for (int i = 0; i < 11; i++)
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                    vecs[i].dbz, vecs[i].lat, qg, rg);

        // Backpressure: 100/9 held in DONE, stray in_valid during CALC/DONE ignored
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd100;
        divisor   = 4'd9;
        @(negedge clk);
        dividend = 8'd3;
        divisor  = 4'd1;
        seen = 0;
        while (!out_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("bp latency", 32'(seen), 9);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 1);
            check($sformatf("bp%0d quotient", k), 32'(quotient), 11);
            check($sformatf("bp%0d remainder", k), 32'(remainder), 1);
            @(negedge clk);
        end
        check("bp held out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp single handshake", 32'(out_valid), 0);
        check("bp in_ready", 32'(in_ready), 1);

        // Reset in the fourth CALC cycle of 250/3 aborts the divide
        in_valid = 1'b1;
        dividend = 8'd250;
        divisor  = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 0);
        check("abort in_ready", 32'(in_ready), 1);
        check("abort quotient", 32'(quotient), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("fresh 250/3", 8'd250, 4'd3, 8'd83, 4'd1, 1'b0, 9, qg, rg);

        // Reset while a result waits in DONE drops out_valid at once
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd200;
        divisor   = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("done-abort valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("done-abort out_valid", 32'(out_valid), 0);
        check("done-abort in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep against a reference model
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                int eq, er;
                eq = (b == 0) ? 255 : a / b;
                er = (b == 0) ? (a % 16) : a % b;
                run_div($sformatf("sweep %0d/%0d", a, b), OW'(a), IW'(b), OW'(eq), IW'(er),
                        (b == 0), (b == 0) ? 0 : 9, qg, rg);
                if (b != 0)
                    check($sformatf("identity %0d/%0d", a, b),
                          32'(int'(qg) * b + int'(rg)), 32'(a));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
